npn_canon: RTL and testbench

Sequential NPN canonicalizer for 4-input Boolean functions; sits directly upstream of the per-class exact-synthesis MIG netlists. It accepts a 16-bit truth table and scans all 768 NPN transforms (24 input permutations × 16 input-negation masks × 2 output polarities). It returns the class representative, defined as the numerically smallest transformed truth table, together with the transform that produces it. The downstream stage uses the representative to select a class netlist and uses the transform to rewire that netlist's inputs and output.

---
 rtl/npn_pkg.sv | 49 ++++
 rtl/npn_canon_if.sv | 28 ++
 rtl/npn_apply.sv | 37 +++
 rtl/npn_canon.sv | 132 +++++++++++++
 tb/tb_npn_canon.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/npn_pkg.sv
// npn_canon shared types: truth-table type, permutation table,
// FSM state encoding, candidate record and first-wins min helper.
package npn_pkg;

  typedef logic [15:0] tt4_t;

  localparam int N_PERM = 24;
  localparam int N_NEG  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } npn_state_e;

  // Entry [k] is p[k]; rows in lexicographic order of (p0,p1,p2,p3).
  localparam logic [1:0] PERM_TBL [N_PERM][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd0, 2'd1, 2'd3, 2'd2},
    '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd0, 2'd2, 2'd3, 2'd1},
    '{2'd0, 2'd3, 2'd1, 2'd2}, '{2'd0, 2'd3, 2'd2, 2'd1},
    '{2'd1, 2'd0, 2'd2, 2'd3}, '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd1, 2'd2, 2'd0, 2'd3}, '{2'd1, 2'd2, 2'd3, 2'd0},
    '{2'd1, 2'd3, 2'd0, 2'd2}, '{2'd1, 2'd3, 2'd2, 2'd0},
    '{2'd2, 2'd0, 2'd1, 2'd3}, '{2'd2, 2'd0, 2'd3, 2'd1},
    '{2'd2, 2'd1, 2'd0, 2'd3}, '{2'd2, 2'd1, 2'd3, 2'd0},
    '{2'd2, 2'd3, 2'd0, 2'd1}, '{2'd2, 2'd3, 2'd1, 2'd0},
    '{2'd3, 2'd0, 2'd1, 2'd2}, '{2'd3, 2'd0, 2'd2, 2'd1},
    '{2'd3, 2'd1, 2'd0, 2'd2}, '{2'd3, 2'd1, 2'd2, 2'd0},
    '{2'd3, 2'd2, 2'd0, 2'd1}, '{2'd3, 2'd2, 2'd1, 2'd0}
  };

  // tt is 17 bits so 0x10000 loses to every real candidate.
  typedef struct packed {
    logic [16:0] tt;
    logic [4:0]  perm;
    logic [3:0]  neg;
    logic        oneg;
  } cand_t;

  localparam cand_t SENTINEL = '{
    tt: 17'h10000, perm: 5'd0, neg: 4'd0, oneg: 1'b0
  };

  // a precedes b in scan order; b wins only if strictly smaller.
  function automatic cand_t pick(cand_t a, cand_t b);
    return (b.tt < a.tt) ? b : a;
  endfunction

endpackage

// File: rtl/npn_canon_if.sv
// npn_canon job interface: input handshake + tt,
// output handshake + canon/perm/neg/oneg. slave = canonicalizer side.
interface npn_canon_if;
  import npn_pkg::*;

  logic       in_valid;
  logic       in_ready;
  tt4_t       in_tt;
  logic       out_valid;
  logic       out_ready;
  tt4_t       out_canon;
  logic [4:0] out_perm;
  logic [3:0] out_neg;
  logic       out_oneg;

  modport master (
    output in_valid, in_tt, out_ready,
    input  in_ready, out_valid, out_canon,
    input  out_perm, out_neg, out_oneg
  );

  modport slave (
    input  in_valid, in_tt, out_ready,
    output in_ready, out_valid, out_canon,
    output out_perm, out_neg, out_oneg
  );

endinterface

// File: rtl/npn_apply.sv
// Applies one NPN transform to a 4-input truth table.
// in: tt, perm index, neg mask, oneg; out: cand.
module npn_apply
  import npn_pkg::*;
(
  input  tt4_t       tt,
  input  logic [4:0] perm,
  input  logic [3:0] neg,
  input  logic       oneg,
  output tt4_t       cand
);

  logic [1:0] p [4];
  logic [3:0] iv;
  logic [3:0] j;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      p[k] = PERM_TBL[perm][k];
    end
  end

  // cand[i] = oneg ^ tt[j], j[k] = i[p[k]] ^ neg[k]
  always_comb begin
    cand = '0;
    iv   = '0;
    j    = '0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      for (int k = 0; k < 4; k++) begin
        j[k] = iv[p[k]] ^ neg[k];
      end
      cand[i] = tt[j] ^ oneg;
    end
  end

endmodule

// File: rtl/npn_canon.sv
// Sequential NPN canonicalizer, PAR masks per cycle.
// Ports: clk, rst_n (sync, low), bus (npn_canon_if.slave).
module npn_canon
  import npn_pkg::*;
#(
  parameter int PAR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  npn_canon_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_SCAN = 2'(SCAN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam int NC = 2 * PAR;
  localparam int NN = 2 * NC - 1;
  localparam logic [3:0] M_STEP = 4'(PAR);
  localparam logic [3:0] M_LAST = 4'(N_NEG - PAR);
  localparam logic [4:0] P_LAST = 5'(N_PERM - 1);

  logic [1:0] state;
  tt4_t       tt_q;
  logic [4:0] perm_q;
  logic [3:0] mbase;
  logic       drain;
  cand_t      best;
  cand_t      grp;
  cand_t      fin;
  cand_t      node [NN];
  tt4_t       cand [NC];

  tt4_t       canon_o;
  logic [4:0] perm_o;
  logic [3:0] neg_o;
  logic       oneg_o;

  // Leaf 2*j+o is mask mbase+j, polarity o: scan order.
  for (genvar g = 0; g < NC; g++) begin : g_app
    npn_apply u_apply (
      .tt   (tt_q),
      .perm (perm_q),
      .neg  (mbase + 4'(g / 2)),
      .oneg (1'(g % 2)),
      .cand (cand[g])
    );
  end

  // Heap-ordered tree; left child is earlier so ties keep it.
  always_comb begin
    for (int n = 0; n < NN; n++) begin
      node[n] = SENTINEL;
    end
    for (int n = 0; n < NC; n++) begin
      node[NC-1+n].tt   = {1'b0, cand[n]};
      node[NC-1+n].perm = perm_q;
      node[NC-1+n].neg  = mbase + 4'(n / 2);
      node[NC-1+n].oneg = 1'(n % 2);
    end
    for (int n = NC - 2; n >= 0; n--) begin
      node[n] = pick(node[2*n+1], node[2*n+2]);
    end
  end

  // Group winners are registered, then merged a cycle later.
  assign fin = pick(best, grp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tt_q    <= '0;
      perm_q  <= '0;
      mbase   <= '0;
      drain   <= 1'b0;
      best    <= SENTINEL;
      grp     <= SENTINEL;
      canon_o <= '0;
      perm_o  <= '0;
      neg_o   <= '0;
      oneg_o  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            tt_q   <= bus.in_tt;
            perm_q <= '0;
            mbase  <= '0;
            drain  <= 1'b0;
            best   <= SENTINEL;
            grp    <= SENTINEL;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          best <= fin;
          if (drain) begin
            canon_o <= fin.tt[15:0];
            perm_o  <= fin.perm;
            neg_o   <= fin.neg;
            oneg_o  <= fin.oneg;
            state   <= S_DONE;
          end else begin
            grp   <= node[0];
            mbase <= mbase + M_STEP;
            if (mbase == M_LAST) begin
              if (perm_q == P_LAST) begin
                drain <= 1'b1;
              end else begin
                perm_q <= perm_q + 5'd1;
              end
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n & (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_canon = canon_o;
  assign bus.out_perm  = perm_o;
  assign bus.out_neg   = neg_o;
  assign bus.out_oneg  = oneg_o;

endmodule

// File: tb/tb_npn_canon.sv
// Bench for npn_canon at PAR=1 and PAR=16 with a
// queue of reference-model results checked per job.
module tb_npn_canon;

  typedef struct packed {
    logic [15:0] canon;
    logic [4:0]  perm;
    logic [3:0]  neg;
    logic        oneg;
  } res_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  res_t exp_q [$];

  npn_canon_if b0 ();
  npn_canon_if b1 ();

  npn_canon #(.PAR(1)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  npn_canon #(.PAR(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void perm_of(input int idx, output int p0,
                                  output int p1, output int p2,
                                  output int p3);
    int n;
    n = 0;
    p0 = 0; p1 = 1; p2 = 2; p3 = 3;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          if (b != a && c != a && c != b) begin
            if (n == idx) begin
              p0 = a; p1 = b; p2 = c; p3 = 6 - a - b - c;
            end
            n++;
          end
  endfunction

  function automatic logic [15:0] xform(input logic [15:0] tt,
                                        input int p0, input int p1,
                                        input int p2, input int p3,
                                        input logic [3:0] m,
                                        input logic o);
    logic [15:0] r;
    logic [3:0]  iv;
    logic [3:0]  j;
    int          pp [4];
    pp = '{p0, p1, p2, p3};
    r = '0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      for (int k = 0; k < 4; k++) j[k] = iv[pp[k]] ^ m[k];
      r[i] = tt[j] ^ o;
    end
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] tt);
    logic [16:0] bst;
    logic [15:0] c;
    res_t        r;
    int          p0, p1, p2, p3;
    bst = 17'h10000;
    r = '0;
    for (int pi = 0; pi < 24; pi++) begin
      perm_of(pi, p0, p1, p2, p3);
      for (int m = 0; m < 16; m++)
        for (int o = 0; o < 2; o++) begin
          c = xform(tt, p0, p1, p2, p3, 4'(m), 1'(o));
          if ({1'b0, c} < bst) begin
            bst = {1'b0, c};
            r = res_t'{c, 5'(pi), 4'(m), 1'(o)};
          end
        end
    end
    return r;
  endfunction

  function automatic res_t get_res(input bit sel);
    if (sel)
      return {b1.out_canon, b1.out_perm, b1.out_neg, b1.out_oneg};
    return {b0.out_canon, b0.out_perm, b0.out_neg, b0.out_oneg};
  endfunction

  function automatic logic get_ov(input bit sel);
    return sel ? b1.out_valid : b0.out_valid;
  endfunction

  function automatic logic get_ir(input bit sel);
    return sel ? b1.in_ready : b0.in_ready;
  endfunction

  task automatic set_in(input bit sel, input logic v,
                        input logic [15:0] tt);
    if (sel) begin
      b1.in_valid = v; b1.in_tt = tt;
    end else begin
      b0.in_valid = v; b0.in_tt = tt;
    end
  endtask

  task automatic set_ordy(input bit sel, input logic v);
    if (sel) b1.out_ready = v;
    else     b0.out_ready = v;
  endtask

  task automatic send(input bit sel, input logic [15:0] tt,
                      input res_t e);
    int n;
    n = 0;
    while (!get_ir(sel) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(get_ir(sel)), 1);
    set_in(sel, 1'b1, tt);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, 16'($urandom));
    chk("busy_ready", 32'(get_ir(sel)), 0);
  endtask

  task automatic recv(input bit sel, input logic [15:0] tt);
    int   lat;
    int   p0, p1, p2, p3;
    res_t got;
    res_t e;
    lat = 0;
    while (!get_ov(sel) && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), sel ? 32'd25 : 32'd385);
    got = get_res(sel);
    chk("queue_size", 32'(exp_q.size()), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("canon", 32'(got.canon), 32'(e.canon));
      chk("perm", 32'(got.perm), 32'(e.perm));
      chk("neg", 32'(got.neg), 32'(e.neg));
      chk("oneg", 32'(got.oneg), 32'(e.oneg));
    end
    perm_of(int'(got.perm), p0, p1, p2, p3);
    chk("replay",
        32'(xform(tt, p0, p1, p2, p3, got.neg, got.oneg)),
        32'(got.canon));
  endtask

  task automatic release_out(input bit sel);
    set_ordy(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    chk("ov_after", 32'(get_ov(sel)), 0);
    chk("ir_after", 32'(get_ir(sel)), 1);
  endtask

  task automatic job(input bit sel, input logic [15:0] tt,
                     input res_t e);
    send(sel, tt, e);
    recv(sel, tt);
    release_out(sel);
  endtask

  initial begin
    res_t        e;
    logic [15:0] t;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_ir0", 32'(get_ir(0)), 0);
    chk("rst_ov0", 32'(get_ov(0)), 0);
    chk("rst_res0", 32'(get_res(0)), 0);
    chk("rst_ir1", 32'(get_ir(1)), 0);
    chk("rst_ov1", 32'(get_ov(1)), 0);
    chk("rst_res1", 32'(get_res(1)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ir0", 32'(get_ir(0)), 1);
    chk("idle_ir1", 32'(get_ir(1)), 1);

    job(0, 16'h0000, res_t'{16'h0000, 5'd0, 4'h0, 1'b0});
    job(0, 16'hFFFF, res_t'{16'h0000, 5'd0, 4'h0, 1'b1});
    job(0, 16'h8000, res_t'{16'h0001, 5'd0, 4'hF, 1'b0});
    job(0, 16'hAAAA, res_t'{16'h00FF, 5'd18, 4'h0, 1'b1});
    job(1, 16'hAAAA, res_t'{16'h00FF, 5'd18, 4'h0, 1'b1});
    job(1, 16'h8000, res_t'{16'h0001, 5'd0, 4'hF, 1'b0});

    e = model(16'h6996);
    send(0, 16'h6996, e);
    recv(0, 16'h6996);
    set_in(0, 1'b1, 16'h1234);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_ov", 32'(get_ov(0)), 1);
      chk("hold_ir", 32'(get_ir(0)), 0);
      chk("hold_res", 32'(get_res(0)), 32'(e));
    end
    set_ordy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(0, 1'b0);
    chk("hs_ov", 32'(get_ov(0)), 0);
    chk("hs_ir", 32'(get_ir(0)), 1);
    exp_q.push_back(model(16'h1234));
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0);
    chk("late_busy", 32'(get_ir(0)), 0);
    recv(0, 16'h1234);
    release_out(0);

    send(0, 16'h1EE7, model(16'h1EE7));
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ov", 32'(get_ov(0)), 0);
    chk("mid_rst_ir", 32'(get_ir(0)), 0);
    chk("mid_rst_res", 32'(get_res(0)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ov", 32'(get_ov(0)), 0);
    chk("post_rst_ir", 32'(get_ir(0)), 1);
    exp_q.delete();

    for (int n = 0; n < 100; n++) begin
      t = 16'($urandom);
      job(0, t, model(t));
    end
    for (int n = 0; n < 500; n++) begin
      t = 16'($urandom);
      job(1, t, model(t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
